// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: latches one request in IDLE, issues it for one cycle, and
// returns read data one cycle later. Define DMEM_ARB_RR_EN for round-robin tie-breaking.
module dmem_arbiter #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

  state_e        state_q, state_d;
  // last_owner_q doubles as the owner of the access in flight; it is only loaded in IDLE.
  logic          last_owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          cmd_load;
  logic          win;

  // Winner select: 1 picks port 1.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
      win = ~last_owner_q;
`else
      win = 1'b0;
`endif
    end else if (req1) begin
      win = 1'b1;
    end
  end

  assign cmd_load = (state_q == StIdle) && (req0 || req1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req0 || req1) state_d = StIssue;
      StIssue:  state_d = we_q ? StIdle : StRdWait;
      StRdWait: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (cmd_load) begin
      last_owner_q <= win;
      we_q         <= win ? we1    : we0;
      addr_q       <= win ? addr1  : addr0;
      wdata_q      <= win ? wdata1 : wdata0;
    end
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIssue: begin
        gnt0      = ~last_owner_q;
        gnt1      = last_owner_q;
        mem_wr_en = we_q;
        mem_rd_en = ~we_q;
      end
      StRdWait: begin
        rvalid0 = ~last_owner_q;
        rvalid1 = last_owner_q;
        if (last_owner_q) rdata1 = mem_data_out;
        else              rdata0 = mem_data_out;
      end
      default: ;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

`ifndef SYNTHESIS
  exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt0 && gnt1) && !(rvalid0 && rvalid1));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a registered-read memory model.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;
`ifdef DMEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  // ctl = {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, mem_rd_en, busy}
  localparam logic [6:0] CIdle = 7'b0000000;
  localparam logic [6:0] CG0W  = 7'b1000101;
  localparam logic [6:0] CG0R  = 7'b1000011;
  localparam logic [6:0] CG1W  = 7'b0100101;
  localparam logic [6:0] CG1R  = 7'b0100011;
  localparam logic [6:0] CV0   = 7'b0010001;
  localparam logic [6:0] CV1   = 7'b0001001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr_en, mem_rd_en;
  logic [DW-1:0] rdata0, rdata1, mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic [AW-1:0] mem_addr;
  logic [6:0]    ctl;
  logic [DW-1:0] mem [64];

  int vec_cnt = 0;
  int err_cnt = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign ctl = {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, mem_rd_en, busy};

  // Memory preloads word i with 16'hA000 | i on every reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 | 16'(i);
      mem_data_out <= '0;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_data_in;
      if (mem_rd_en) mem_data_out <= mem[mem_addr];
    end
  end

  task automatic test_reset;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CIdle) begin
      err_cnt++; $display("FAIL reset_ctl got %b want %b", ctl, CIdle);
    end
    vec_cnt++;
    if ({rdata0, rdata1, mem_addr, mem_data_in} !== '0) begin
      err_cnt++; $display("FAIL reset_data got %h/%h/%h/%h want 0", rdata0, rdata1, mem_addr,
                          mem_data_in);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd4;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG0R || mem_addr !== 6'd4) begin
      err_cnt++; $display("FAIL first_arb got %b/%h want %b/4", ctl, mem_addr, CG0R);
    end
    req0 = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CV0 || rdata0 !== 16'hA004) begin
      err_cnt++; $display("FAIL first_read got %b/%h want %b/a004", ctl, rdata0, CV0);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read;
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 16'hBEEF;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG0W || mem_addr !== 6'd5 || mem_data_in !== 16'hBEEF) begin
      err_cnt++; $display("FAIL wr_issue got %b/%h/%h want %b/5/beef", ctl, mem_addr,
                          mem_data_in, CG0W);
    end
    req0 = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CIdle) begin
      err_cnt++; $display("FAIL wr_done got %b want %b", ctl, CIdle);
    end
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG0R || mem_addr !== 6'd5) begin
      err_cnt++; $display("FAIL rd_issue got %b/%h want %b/5", ctl, mem_addr, CG0R);
    end
    req0 = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CV0 || rdata0 !== 16'hBEEF) begin
      err_cnt++; $display("FAIL rd_data got %b/%h want %b/beef", ctl, rdata0, CV0);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CIdle) begin
      err_cnt++; $display("FAIL rd_done got %b want %b", ctl, CIdle);
    end
  endtask

  task automatic test_write_idle;
    int wr_n = 0, busy_n = 0, rv_n = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_wr_en) wr_n++;
      if (busy) busy_n++;
      if (rvalid0 || rvalid1) rv_n++;
      if (gnt1) req1 = 1'b0;
    end
    vec_cnt++;
    if (wr_n != 1) begin err_cnt++; $display("FAIL wr_cycles got %0d want 1", wr_n); end
    vec_cnt++;
    if (busy_n != 1) begin err_cnt++; $display("FAIL wr_busy got %0d want 1", busy_n); end
    vec_cnt++;
    if (rv_n != 0) begin err_cnt++; $display("FAIL wr_rvalid got %0d want 0", rv_n); end
    req1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_contention;
    logic [6:0] exp_g, exp_v;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 6'd1; addr1 = 6'd2;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG0R || mem_addr !== 6'd1) begin
      err_cnt++; $display("FAIL cont_g1 got %b/%h want %b/1", ctl, mem_addr, CG0R);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CV0 || rdata0 !== 16'hA001) begin
      err_cnt++; $display("FAIL cont_v1 got %b/%h want %b/a001", ctl, rdata0, CV0);
    end
    @(negedge clk);
    exp_g = RrEn ? CG1R : CG0R;
    exp_v = RrEn ? CV1 : CV0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== exp_g || mem_addr !== (RrEn ? 6'd2 : 6'd1)) begin
      err_cnt++; $display("FAIL cont_g2 got %b/%h want %b", ctl, mem_addr, exp_g);
    end
    @(negedge clk);
    vec_cnt++;
    if (ctl !== exp_v || (RrEn ? rdata1 : rdata0) !== (RrEn ? 16'hA002 : 16'hA001)) begin
      err_cnt++; $display("FAIL cont_v2 got %b/%h/%h want %b", ctl, rdata0, rdata1, exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG0R) begin
      err_cnt++; $display("FAIL cont_g3 got %b want %b", ctl, CG0R);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_addr_change;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd3;
    @(posedge clk); #1 addr1 = 6'd7;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG1R || mem_addr !== 6'd3) begin
      err_cnt++; $display("FAIL addr_hold got %b/%h want %b/3", ctl, mem_addr, CG1R);
    end
    req1 = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CV1 || rdata1 !== 16'hA003) begin
      err_cnt++; $display("FAIL addr_data got %b/%h want %b/a003", ctl, rdata1, CV1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int stray = 0;
    // Abort during ISSUE of a port 0 read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
    @(posedge clk); #2;
    req0 = 1'b0;
    rst_n = 1'b0; #1;
    vec_cnt++;
    if (ctl !== CIdle) begin
      err_cnt++; $display("FAIL issue_abort got %b want %b", ctl, CIdle);
    end
    @(negedge clk); rst_n = 1'b1;
    // Abort during RDWAIT of a port 1 read.
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
    @(negedge clk);
    vec_cnt++;
    if (ctl !== CG1R) begin
      err_cnt++; $display("FAIL abort_g got %b want %b", ctl, CG1R);
    end
    req1 = 1'b0;
    @(posedge clk); #2;
    vec_cnt++;
    if (ctl !== CV1) begin
      err_cnt++; $display("FAIL abort_v got %b want %b", ctl, CV1);
    end
    rst_n = 1'b0; #1;
    vec_cnt++;
    if (ctl !== CIdle || {rdata0, rdata1, mem_addr, mem_data_in} !== '0) begin
      err_cnt++; $display("FAIL rdwait_abort got %b/%h/%h want 0", ctl, rdata1, mem_addr);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ctl !== CIdle) stray++;
    end
    vec_cnt++;
    if (stray != 0) begin
      err_cnt++; $display("FAIL post_abort got %0d active cycles want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_idle();
    test_contention();
    test_addr_change();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
